// File: rtl/sha2_padding_pkg.sv
// Shared constants and state encoding for the SHA-2 message padding stage.
package sha2_padding_pkg;

    localparam logic       SHA2_256        = 1'b0;
    localparam logic       SHA2_512        = 1'b1;
    localparam logic [7:0] PAD_BYTE        = 8'h80;
    localparam int         WORDS_PER_BLOCK = 16;
    localparam logic [3:0] LEN_WORD_HI     = 4'd14;
    localparam logic [3:0] LEN_WORD_LO     = 4'd15;
    localparam logic [3:0] LAST_WORD       = 4'(WORDS_PER_BLOCK - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_PAD1,
        ST_ZERO,
        ST_LEN,
        ST_WAIT
    } state_t;

endpackage

// File: rtl/sha2_pad_word.sv
// Combinational byte masking: keeps the first nbytes bytes (MSB first), puts 0x80
// in the next byte and zeros below. A full word (nbytes = W/8) passes unchanged.
module sha2_pad_word
    import sha2_padding_pkg::*;
(
    input  logic [63:0] data,
    input  logic [3:0]  nbytes,
    input  logic        mode,
    output logic [63:0] word
);

    logic [63:0] word64;
    logic [31:0] word32;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane64
            assign word64[63-8*gi -: 8] = (4'(gi) < nbytes)  ? data[63-8*gi -: 8] :
                                          (4'(gi) == nbytes) ? PAD_BYTE : 8'h00;
        end
        for (gi = 0; gi < 4; gi++) begin : g_lane32
            assign word32[31-8*gi -: 8] = (4'(gi) < nbytes)  ? data[31-8*gi -: 8] :
                                          (4'(gi) == nbytes) ? PAD_BYTE : 8'h00;
        end
    endgenerate

    assign word = (mode == SHA2_256) ? {32'h0, word32} : word64;

endmodule

// File: rtl/sha2_padding.sv
// SHA-2 padding stage: streams message words into 16-word padded blocks for the schedule.
// Optional SHA2_PAD_ERR_EN adds a sticky pad_err flag for out-of-range in_bytes.
module sha2_padding
    import sha2_padding_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mode_sha2,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic        in_last,
    input  logic [3:0]  in_bytes,
    input  logic        next_block,
    output logic        load,
    output logic [63:0] data_out,
    output logic        block_valid,
    output logic        block_last,
    output logic        pad_err
);

    state_t           state_q, state_d;
    state_t           resume_q, resume_d;
    logic [3:0]       word_cnt_q, word_cnt_d;
    logic [LEN_W-1:0] bit_len_q, bit_len_d;
    logic             mode_q, mode_d;
    logic             in_ready_q, in_ready_d;
    logic             load_q, load_d;
    logic [63:0]      data_q, data_d;
    logic             block_valid_q, block_valid_d;
    logic             block_last_q, block_last_d;

    logic             mode_eff;
    logic [3:0]       full_bytes;
    logic             accept;
    logic             bytes_bad;
    logic [3:0]       eff_bytes;
    logic             word_full;
    logic [3:0]       add_bytes;
    logic [63:0]      pad_word;
    logic [63:0]      pad_msb;
    logic [63:0]      len_ext;
    logic [LEN_W-1:0] len_base;
    state_t           pad_next;
    logic             emit;
    logic [63:0]      emit_word;

    always_comb begin
        mode_eff   = (state_q == ST_IDLE) ? mode_sha2 : mode_q;
        full_bytes = (mode_eff == SHA2_512) ? 4'd8 : 4'd4;
        accept     = in_valid && in_ready_q;
`ifdef SHA2_PAD_ERR_EN
        bytes_bad  = in_last && (in_bytes > full_bytes);
`else
        bytes_bad  = 1'b0;
`endif
        eff_bytes  = (!in_last || bytes_bad) ? full_bytes : in_bytes;
        word_full  = (eff_bytes >= full_bytes);
        add_bytes  = word_full ? full_bytes : eff_bytes;
        pad_msb    = (mode_eff == SHA2_512) ? {PAD_BYTE, 56'h0} : {32'h0, PAD_BYTE, 24'h0};
        len_ext    = 64'(bit_len_q);
        len_base   = (state_q == ST_IDLE) ? '0 : bit_len_q;
        // A pad marker in the last two slots leaves no room for the length field.
        if (word_cnt_q == LAST_WORD)
            pad_next = ST_WAIT;
        else if (word_cnt_q == LEN_WORD_HI - 4'd1)
            pad_next = ST_LEN;
        else
            pad_next = ST_ZERO;
    end

    sha2_pad_word u_pad_word (
        .data   (in_data),
        .nbytes (eff_bytes),
        .mode   (mode_eff),
        .word   (pad_word)
    );

    always_comb begin
        state_d       = state_q;
        resume_d      = resume_q;
        word_cnt_d    = word_cnt_q;
        bit_len_d     = bit_len_q;
        mode_d        = mode_q;
        block_valid_d = block_valid_q;
        block_last_d  = block_last_q;
        emit          = 1'b0;
        emit_word     = 64'h0;

        case (state_q)
            ST_IDLE, ST_DATA: begin
                if (accept) begin
                    emit      = 1'b1;
                    emit_word = pad_word;
                    mode_d    = mode_eff;
                    bit_len_d = len_base + LEN_W'({add_bytes, 3'b000});
                    if (!in_last) begin
                        state_d  = (word_cnt_q == LAST_WORD) ? ST_WAIT : ST_DATA;
                        resume_d = ST_DATA;
                    end else if (word_full) begin
                        state_d  = (word_cnt_q == LAST_WORD) ? ST_WAIT : ST_PAD1;
                        resume_d = ST_PAD1;
                    end else begin
                        state_d  = pad_next;
                        resume_d = ST_ZERO;
                    end
                end
            end
            ST_PAD1: begin
                emit      = 1'b1;
                emit_word = pad_msb;
                state_d   = pad_next;
                resume_d  = ST_ZERO;
            end
            ST_ZERO: begin
                emit     = 1'b1;
                resume_d = ST_ZERO;
                if (word_cnt_q == LAST_WORD)
                    state_d = ST_WAIT;
                else if (word_cnt_q == LEN_WORD_HI - 4'd1)
                    state_d = ST_LEN;
            end
            ST_LEN: begin
                emit = 1'b1;
                if (word_cnt_q == LEN_WORD_LO) begin
                    emit_word    = (mode_q == SHA2_512) ? len_ext : {32'h0, len_ext[31:0]};
                    state_d      = ST_WAIT;
                    resume_d     = ST_IDLE;
                    block_last_d = 1'b1;
                end else begin
                    emit_word = (mode_q == SHA2_512) ? 64'h0 : {32'h0, len_ext[63:32]};
                end
            end
            ST_WAIT: begin
                // block_valid rises one cycle after the 16th load; next_block counts only once it is up.
                if (block_valid_q && next_block) begin
                    block_valid_d = 1'b0;
                    block_last_d  = 1'b0;
                    word_cnt_d    = 4'd0;
                    state_d       = resume_q;
                    if (resume_q == ST_IDLE)
                        bit_len_d = '0;
                end else begin
                    block_valid_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        load_d = emit;
        data_d = emit ? emit_word : data_q;
        if (emit)
            word_cnt_d = word_cnt_q + 4'd1;
        in_ready_d = (state_d == ST_IDLE) || (state_d == ST_DATA);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            resume_q      <= ST_IDLE;
            word_cnt_q    <= 4'd0;
            bit_len_q     <= '0;
            mode_q        <= SHA2_256;
            in_ready_q    <= 1'b0;
            load_q        <= 1'b0;
            data_q        <= 64'h0;
            block_valid_q <= 1'b0;
            block_last_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            resume_q      <= resume_d;
            word_cnt_q    <= word_cnt_d;
            bit_len_q     <= bit_len_d;
            mode_q        <= mode_d;
            in_ready_q    <= in_ready_d;
            load_q        <= load_d;
            data_q        <= data_d;
            block_valid_q <= block_valid_d;
            block_last_q  <= block_last_d;
        end
    end

`ifdef SHA2_PAD_ERR_EN
    logic pad_err_q, pad_err_d;

    always_comb begin
        pad_err_d = pad_err_q || (accept && bytes_bad);
    end

    always_ff @(posedge clk) begin
        if (!rst)
            pad_err_q <= 1'b0;
        else
            pad_err_q <= pad_err_d;
    end

    assign pad_err = pad_err_q;
`else
    assign pad_err = 1'b0;
`endif

    assign in_ready    = in_ready_q;
    assign load        = load_q;
    assign data_out    = data_q;
    assign block_valid = block_valid_q;
    assign block_last  = block_last_q;

endmodule

// File: tb/tb_sha2_padding.sv
// Randomized scoreboard bench for sha2_padding against a byte-level padding model.
module tb_sha2_padding;

    logic        clk;
    logic        rst;
    logic        mode_sha2;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        in_last;
    logic [3:0]  in_bytes;
    logic        next_block;
    logic        load;
    logic [63:0] data_out;
    logic        block_valid;
    logic        block_last;
    logic        pad_err;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic        blk_q[$];
    logic        mon_en = 1'b0;
    logic        bv_prev = 1'b0;
    int          load_cnt = 0;
    int          nb_fixed = -1;
    logic        spurious_en = 1'b0;

    sha2_padding #(.LEN_W(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .mode_sha2   (mode_sha2),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_bytes    (in_bytes),
        .next_block  (next_block),
        .load        (load),
        .data_out    (data_out),
        .block_valid (block_valid),
        .block_last  (block_last),
        .pad_err     (pad_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: pad the message as a byte string, then cut it into words and blocks.
    task automatic model(input logic m, input logic [7:0] msg[$]);
        logic [7:0]      s[$];
        int              wb = m ? 8 : 4;
        int              blk = 16 * wb;
        int              lenb = 2 * wb;
        longint unsigned bits;
        s = msg;
        bits = 64'(msg.size()) * 64'd8;
        s.push_back(8'h80);
        while ((s.size() % blk) != blk - lenb) s.push_back(8'h00);
        for (int i = lenb - 1; i >= 0; i--)
            s.push_back((i < 8) ? 8'(bits >> (8 * i)) : 8'h00);
        for (int w = 0; w < s.size() / wb; w++) begin
            logic [63:0] word = 64'h0;
            for (int b = 0; b < wb; b++) word = (word << 8) | 64'(s[w * wb + b]);
            exp_q.push_back(word);
            if (w % 16 == 15) blk_q.push_back(w == s.size() / wb - 1);
        end
    endtask

    task automatic send_word(input logic m, input logic [63:0] d, input logic last,
                             input logic [3:0] nb);
        int guard = 0;
        repeat ($urandom_range(3) == 0 ? 1 : 0) @(negedge clk);
        mode_sha2 = m;
        in_data   = d;
        in_last   = last;
        in_bytes  = nb;
        in_valid  = 1'b1;
        while (!in_ready && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout got=%0b want=1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_msg(input logic m, input logic [7:0] msg[$], input logic empty_tail);
        int wb = m ? 8 : 4;
        int len = msg.size();
        int nfull = len / wb;
        int rem = len % wb;
        int nwords = nfull + ((rem > 0 || empty_tail || len == 0) ? 1 : 0);
        model(m, msg);
        for (int w = 0; w < nwords; w++) begin
            logic [63:0] d = {$urandom, $urandom};
            int          nb = (w < nfull) ? wb : rem;
            logic        last = (w == nwords - 1);
            for (int b = 0; b < nb; b++) begin
                if (m) d[63 - 8 * b -: 8] = msg[w * wb + b];
                else   d[31 - 8 * b -: 8] = msg[w * wb + b];
            end
            send_word((w == 0) ? m : 1'($urandom_range(1)), d, last,
                      last ? 4'(nb) : 4'($urandom_range(15)));
        end
    endtask

    task automatic send_rand(input logic m, input int len, input logic empty_tail);
        logic [7:0] msg[$];
        for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
        send_msg(m, msg, empty_tail);
    endtask

    task automatic drain();
        int guard = 0;
        while ((exp_q.size() != 0 || blk_q.size() != 0 || !in_ready) && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= 3000) begin
            errors++;
            $display("FAIL drain_timeout words_left=%0d blocks_left=%0d want=0",
                     exp_q.size(), blk_q.size());
            exp_q.delete();
            blk_q.delete();
        end
        checks++;
        if (pad_err !== 1'b0) begin
            errors++;
            $display("FAIL pad_err got=%0b want=0", pad_err);
        end
    endtask

    // Monitor: pops the scoreboard on every load and checks each block boundary.
    initial begin
        logic [63:0] e;
        logic        bl;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (load) begin
                    load_cnt++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL extra_load got=%h want=no_load", data_out);
                    end else begin
                        e = exp_q.pop_front();
                        if (data_out !== e) begin
                            errors++;
                            $display("FAIL data_out got=%h want=%h", data_out, e);
                        end
                    end
                end
                if (block_valid && !bv_prev) begin
                    checks++;
                    if (load_cnt != 16) begin
                        errors++;
                        $display("FAIL block_loads got=%0d want=16", load_cnt);
                    end
                    checks++;
                    if (blk_q.size() == 0) begin
                        errors++;
                        $display("FAIL extra_block got=block want=none");
                    end else begin
                        bl = blk_q.pop_front();
                        if (block_last !== bl) begin
                            errors++;
                            $display("FAIL block_last got=%0b want=%0b", block_last, bl);
                        end
                    end
                    load_cnt = 0;
                end
                if (block_valid) begin
                    checks++;
                    if (load || in_ready) begin
                        errors++;
                        $display("FAIL wait_stall load=%0b in_ready=%0b want=0/0", load, in_ready);
                    end
                end
                bv_prev = block_valid;
            end
        end
    end

    // Schedule model: releases each completed block, sometimes with stray pulses in between.
    initial begin
        next_block = 1'b0;
        forever begin
            @(negedge clk);
            if (block_valid) begin
                repeat ((nb_fixed >= 0) ? nb_fixed : int'($urandom_range(3))) @(negedge clk);
                next_block = 1'b1;
                @(negedge clk);
                next_block = 1'b0;
            end else if (spurious_en && $urandom_range(7) == 0) begin
                next_block = 1'b1;
                @(negedge clk);
                next_block = 1'b0;
            end
        end
    end

    initial begin
        logic [7:0] abc[$];
        int         cnt;
        int         guard;
        abc = '{8'h61, 8'h62, 8'h63};
        rst = 1'b0;
        mode_sha2 = 1'b0;
        in_valid = 1'b0;
        in_data = 64'h0;
        in_last = 1'b0;
        in_bytes = 4'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, load, data_out, block_valid, block_last, pad_err} !== 69'h0) begin
            errors++;
            $display("FAIL reset_values got rdy=%0b ld=%0b d=%h bv=%0b bl=%0b err=%0b want=0",
                     in_ready, load, data_out, block_valid, block_last, pad_err);
        end
        rst = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        send_msg(1'b0, abc, 1'b0);
        drain();
        send_msg(1'b1, abc, 1'b0);
        drain();
        send_rand(1'b0, 56, 1'b0);
        drain();
        send_rand(1'b0, 0, 1'b0);
        drain();
        nb_fixed = 20;
        send_rand(1'b1, 136, 1'b0);
        drain();
        nb_fixed = -1;

        // Abandon a block after 7 loads, then confirm a clean restart.
        mon_en = 1'b0;
        mode_sha2 = 1'b0;
        in_last = 1'b0;
        in_data = {$urandom, $urandom};
        in_valid = 1'b1;
        cnt = 0;
        guard = 0;
        while (cnt < 7 && guard < 100) begin
            @(negedge clk);
            if (load) cnt++;
            guard++;
        end
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (load !== 1'b0 || block_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset ld=%0b bv=%0b rdy=%0b want=0/0/0", load, block_valid, in_ready);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (load !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_idle ld=%0b rdy=%0b want=0/1", load, in_ready);
        end
        exp_q.delete();
        blk_q.delete();
        load_cnt = 0;
        bv_prev = 1'b0;
        mon_en = 1'b1;
        send_msg(1'b0, abc, 1'b0);
        drain();

        spurious_en = 1'b1;
        for (int n = 0; n < 30; n++) begin
            send_rand(1'($urandom_range(1)), int'($urandom_range(300)), 1'($urandom_range(1)));
            drain();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sha2_padding.md
Name: sha2_padding

Overview:
Upstream stage of the SHA-2 message schedule. Accepts a message as a stream of 32/64-bit words and emits padded 512/1024-bit blocks as 16 consecutive single-cycle `load` writes into the schedule's shift memory. Padding covers the 0x80 marker, zero fill and the big-endian bit-length field. Between blocks it stalls until the round controller pulses `next_block`.

Parameters:
LEN_W, 64, width of the internal bit-length counter; upper length bits beyond LEN_W are emitted as zero.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
mode_sha2  in  1  0: SHA-256 (32-bit words on data bits [31:0]); 1: SHA-384/512/512-256 (64-bit words)
in_valid  in  1  input word valid
in_ready  out  1  input word accepted when in_valid & in_ready
in_data  in  64  message word, MSB-first byte order; SHA-256 uses [31:0], [63:32] ignored
in_last  in  1  final word of message
in_bytes  in  4  valid bytes in final word, 0..4 (256) or 0..8 (512); ignored when in_last=0
next_block  in  1  pulse: schedule has consumed the current block, start loading the next
load  out  1  one-cycle write strobe to schedule
data_out  out  64  padded word; SHA-256 zero-extended to 64 bits
block_valid  out  1  level: 16 words loaded, waiting for next_block
block_last  out  1  qualifies block_valid: final block of message
pad_err  out  1  sticky input-error flag (see Optional Feature)

Behaviour:
- Interface: one clock, `clk`. `rst` is synchronous and active-low. When `!rst` at a posedge, the block enters IDLE.
- Reset values: in_ready=0, load=0, data_out=0, block_valid=0, block_last=0, pad_err=0, word_cnt=0, bit_len=0.
- Word width W is 32 or 64. mode_sha2 is latched at the first accepted word of each message; changes mid-message are ignored.
- Outputs load and data_out are registered: an accepted word appears as load=1 on the next cycle. Zero and length words are emitted back-to-back, one per cycle.
- word_cnt (0..15) increments on every load. The 16th load sets block_valid on the following cycle.
- States and transitions:
  - IDLE: in_ready=1. First accepted word → DATA handling.
  - DATA: in_ready=1 while word_cnt<16.
    - Non-last word: emit unchanged; bit_len += W.
    - Last word with in_bytes<W/8: emit bytes [0..in_bytes-1], then 0x80 in byte in_bytes, zeros below; bit_len += 8*in_bytes; → ZERO.
    - Last word with in_bytes=W/8: emit unchanged; → PAD1.
  - PAD1: in_ready=0; emit 0x80 in the MSB byte, zeros elsewhere; → ZERO.
  - ZERO: emit zero words until word_cnt=14 → LEN. If the pad word landed at index 14 or 15: fill to 16, set block_last=0, → WAIT, and the next block is 14 zeros + LEN.
  - LEN:
    - SHA-256: word 14 = bit_len[63:32], word 15 = bit_len[31:0].
    - SHA-512: word 14 = 0 (bits above LEN_W), word 15 = bit_len zero-extended.
    - After word 15, block_last=1 → WAIT.
  - WAIT: block_valid=1, in_ready=0. On next_block: clear block_valid and word_cnt.
    - block_last=1 → IDLE; bit_len=0.
    - mid-message data block → DATA.
    - pending pad-only block → ZERO.
- A full 16-data-word block without in_last → WAIT with block_last=0.
- next_block outside WAIT is ignored. next_block coinciding with reset: reset wins.
- bit_len wraps modulo 2^LEN_W.
- in_bytes=0 with in_last: the data word contributes no bytes and the emitted word is 0x80 in the MSB byte (empty-message support).
- Reset mid-block: the partial block is abandoned, with no further loads; the downstream schedule is reset by the same rst.

Optional Feature:
- Macro `SHA2_PAD_ERR_EN`.
- Defined: pad_err sets (sticky until reset) when in_last is accepted with in_bytes>4 (mode 0) or in_bytes>8 (mode 1). The offending word is treated as full (in_bytes=W/8).
- Undefined: the port is present and tied 0; out-of-range in_bytes behaviour is undefined.

Decomposition:
- Shared sha2 package: mode encoding constants (SHA2_256=0, SHA2_512=1), PAD_BYTE=8'h80, WORDS_PER_BLOCK=16, LEN_WORD_HI=14, LEN_WORD_LO=15, state encoding.
- One natural sub-module: sha2_pad_word, a combinational byte-mask/0x80 insertion given (data, in_bytes, mode).
- Counters and FSM stay in sha2_padding.

Test Plan:
- SHA-256 "abc": in_data=32'h61626300, in_bytes=3, in_last → loads: 0x61626380, 13×0, 0x00000000, 0x00000018; block_valid=1, block_last=1.
- SHA-512 "abc": in_data=64'h6162630000000000, in_bytes=3 → 0x6162638000000000, 13×0, 0, 0x18; block_last=1.
- SHA-256 56-byte message (14 full words, last in_bytes=4) → block 1: 14 data, 0x80000000, 0; block_last=0; after next_block, block 2: 14×0, 0x0, 0x000001C0, block_last=1.
- Empty message (in_bytes=0, in_last) in SHA-256 → 0x80000000, 14×0, 0x00000000 length; 16 loads total.
- Backpressure: 17-word SHA-512 message with next_block held low 20 cycles → in_ready=0 and no load during WAIT; resume on next_block pulse; final length 0x440.
- Reset asserted at word_cnt=7 → next cycle load=0, block_valid=0, in_ready=0, then IDLE; a following "abc" message pads correctly.
